// File: rtl/pit_pkg.sv
// Shared types and control-word builders for the 8254 host-side bus initiator.
package pit_pkg;

  typedef enum logic [1:0] {
    OP_PROGRAM = 2'b00,
    OP_LATCH   = 2'b01,
    OP_STATUS  = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  // Which transfer of the current command the bus engine is performing.
  typedef enum logic [1:0] {
    PH_CW  = 2'b00,
    PH_LSB = 2'b01,
    PH_MSB = 2'b10
  } phase_e;

  localparam logic [1:0] A_CTRL  = 2'b11;
  localparam logic [1:0] RW_LSB  = 2'b01;
  localparam logic [1:0] RW_BOTH = 2'b11;

  function automatic logic [7:0] cw_program(input logic [1:0] sc, input logic [1:0] rw,
                                            input logic [2:0] mode, input logic bcd);
    return {sc, rw, mode, bcd};
  endfunction

  function automatic logic [7:0] cw_latch(input logic [1:0] sc);
    return {sc, 2'b00, 4'b0000};
  endfunction

  // Read-back command: latch status only (!COUNT=1, !STATUS=0) for the selected counter.
  function automatic logic [7:0] cw_readback(input logic [1:0] sc);
    logic [2:0] sel;
    sel = 3'b001 << sc;
    return {2'b11, 1'b1, 1'b0, sel, 1'b0};
  endfunction

endpackage

// File: rtl/pit_bus_cycle.sv
// Single 8254 read/write bus-cycle engine: SETUP, STROBE xN, HOLD, RECOV xM.
module pit_bus_cycle import pit_pkg::*; #(
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_write,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic [1:0] a,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
);

  typedef enum logic [2:0] {E_IDLE, E_SETUP, E_STROBE, E_HOLD, E_RECOV} bus_state_e;

  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] RECOV_LAST  = 8'(RECOVERY_CYCLES - 1);

  bus_state_e state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       take, wr_q, wr_eff, bus_active, strobe;

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    take      = 1'b0;
    case (state)
      E_IDLE:   take = start;
      E_SETUP: begin
        state_nxt = E_STROBE;
        cnt_nxt   = '0;
      end
      E_STROBE: begin
        if (cnt == STROBE_LAST) state_nxt = E_HOLD;
        else                    cnt_nxt   = cnt + 8'd1;
      end
      E_HOLD: begin
        if (RECOVERY_CYCLES == 0) begin
          done      = 1'b1;
          take      = start;
          state_nxt = E_IDLE;
        end else begin
          state_nxt = E_RECOV;
          cnt_nxt   = '0;
        end
      end
      E_RECOV: begin
        if (cnt == RECOV_LAST) begin
          done      = 1'b1;
          take      = start;
          state_nxt = E_IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = E_IDLE;
    endcase
    // A new request on the final cycle chains straight into the next SETUP.
    if (take) state_nxt = E_SETUP;
    wr_eff     = take ? is_write : wr_q;
    bus_active = (state_nxt == E_SETUP) || (state_nxt == E_STROBE) || (state_nxt == E_HOLD);
    strobe     = (state_nxt == E_STROBE);
  end

  // Bus pins are registered from the next state so they never glitch.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= E_IDLE;
      cnt   <= '0;
      wr_q  <= 1'b0;
      a     <= 2'b00;
      d_out <= 8'h00;
      cs_n  <= 1'b1;
      rd_n  <= 1'b1;
      wr_n  <= 1'b1;
      d_oe  <= 1'b0;
      rdata <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        wr_q  <= is_write;
        a     <= addr;
        d_out <= wdata;
      end
      cs_n <= !bus_active;
      d_oe <= bus_active && wr_eff;
      wr_n <= !(strobe && wr_eff);
      rd_n <= !(strobe && !wr_eff);
      if (state == E_STROBE && state_nxt == E_HOLD && !wr_q) rdata <= d_in;
    end
  end

endmodule

// File: rtl/pit_host_ctrl.sv
// Host-side 8254 initiator: turns one command into control-word/count bus cycles and returns the result.
module pit_host_ctrl import pit_pkg::*; #(
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_sc,
  input  logic [1:0]  cmd_rw,
  input  logic [2:0]  cmd_mode,
  input  logic        cmd_bcd,
  input  logic [15:0] cmd_count,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_err,
  output logic [15:0] rsp_count,
  output logic [7:0]  rsp_status,
  output logic [1:0]  a,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in
);

  typedef enum logic [1:0] {C_IDLE, C_DECODE, C_BUS, C_RESP} ctrl_state_e;

  ctrl_state_e state, state_nxt;
  phase_e      phase, phase_nxt, phase_after;
  op_e         op_q;
  logic [1:0]  sc_q, rw_q, shadow_sel;
  logic [2:0]  mode_q;
  logic        bcd_q;
  logic [15:0] count_q;
  logic [1:0]  shadow_rw [0:2];

  logic        accept, cmd_err, has_next;
  logic        eng_start, eng_write, eng_done;
  logic [1:0]  eng_addr;
  logic [7:0]  eng_wdata, eng_rdata;

  assign cmd_ready = (state == C_IDLE);
  assign rsp_valid = (state == C_RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_err   = (op_q == OP_RSVD) || (sc_q == 2'b11) || (op_q == OP_PROGRAM && rw_q == 2'b00);

  always_comb begin
    case (sc_q)
      2'd0:    shadow_sel = shadow_rw[0];
      2'd1:    shadow_sel = shadow_rw[1];
      2'd2:    shadow_sel = shadow_rw[2];
      default: shadow_sel = RW_BOTH;
    endcase
  end

  // Transfer order after the control word: LSB (if selected), then MSB (if selected).
  always_comb begin
    has_next    = 1'b0;
    phase_after = PH_MSB;
    case (phase)
      PH_CW: begin
        has_next    = 1'b1;
        phase_after = rw_q[0] ? PH_LSB : PH_MSB;
      end
      PH_LSB:  has_next = rw_q[1];
      default: has_next = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    eng_start = 1'b0;
    eng_write = 1'b0;
    eng_addr  = A_CTRL;
    eng_wdata = 8'h00;
    case (state)
      C_IDLE: if (accept) state_nxt = C_DECODE;
      C_DECODE: begin
        if (cmd_err) begin
          state_nxt = C_RESP;
        end else begin
          eng_start = 1'b1;
          eng_write = 1'b1;
          case (op_q)
            OP_PROGRAM: eng_wdata = cw_program(sc_q, rw_q, mode_q, bcd_q);
            OP_LATCH:   eng_wdata = cw_latch(sc_q);
            default:    eng_wdata = cw_readback(sc_q);
          endcase
          phase_nxt = PH_CW;
          state_nxt = C_BUS;
        end
      end
      C_BUS: begin
        if (eng_done) begin
          if (has_next) begin
            eng_start = 1'b1;
            eng_write = (op_q == OP_PROGRAM);
            eng_addr  = sc_q;
            eng_wdata = (phase_after == PH_LSB) ? count_q[7:0] : count_q[15:8];
            phase_nxt = phase_after;
          end else begin
            state_nxt = C_RESP;
          end
        end
      end
      C_RESP:  if (rsp_ready) state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= C_IDLE;
      phase      <= PH_CW;
      op_q       <= OP_PROGRAM;
      sc_q       <= 2'b00;
      rw_q       <= 2'b00;
      mode_q     <= 3'b000;
      bcd_q      <= 1'b0;
      count_q    <= 16'h0000;
      rsp_err    <= 1'b0;
      rsp_count  <= 16'h0000;
      rsp_status <= 8'h00;
      // NOTE: this small array is reset because reads depend on its value; large data memories normally are not.
      for (int i = 0; i < 3; i++) shadow_rw[i] <= RW_BOTH;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      if (accept) begin
        op_q       <= op_e'(cmd_op);
        sc_q       <= cmd_sc;
        rw_q       <= cmd_rw;
        mode_q     <= cmd_mode;
        bcd_q      <= cmd_bcd;
        count_q    <= cmd_count;
        rsp_err    <= 1'b0;
        rsp_count  <= 16'h0000;
        rsp_status <= 8'h00;
      end
      // Reads take their byte order from the last programmed access mode.
      if (state == C_DECODE) begin
        if (cmd_err)                rsp_err <= 1'b1;
        else if (op_q == OP_LATCH)  rw_q    <= shadow_sel;
        else if (op_q == OP_STATUS) rw_q    <= RW_LSB;
      end
      if (state == C_BUS && eng_done) begin
        if (op_q != OP_PROGRAM && phase != PH_CW) begin
          if (op_q == OP_STATUS)    rsp_status       <= eng_rdata;
          else if (phase == PH_LSB) rsp_count[7:0]   <= eng_rdata;
          else                      rsp_count[15:8]  <= eng_rdata;
        end
        if (op_q == OP_PROGRAM && !has_next) begin
          for (int i = 0; i < 3; i++)
            if (sc_q == 2'(i)) shadow_rw[i] <= rw_q;
        end
      end
    end
  end

  pit_bus_cycle #(
    .STROBE_CYCLES  (STROBE_CYCLES),
    .RECOVERY_CYCLES(RECOVERY_CYCLES)
  ) u_bus (
    .clk     (clk),
    .rst     (rst),
    .start   (eng_start),
    .is_write(eng_write),
    .addr    (eng_addr),
    .wdata   (eng_wdata),
    .done    (eng_done),
    .rdata   (eng_rdata),
    .a       (a),
    .cs_n    (cs_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .d_out   (d_out),
    .d_oe    (d_oe),
    .d_in    (d_in)
  );

endmodule

// File: tb/tb_pit_host_ctrl.sv
// Directed bench for pit_host_ctrl: a vector table plus hand sequences for back-pressure and reset.
module tb_pit_host_ctrl;
  import pit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_sc, cmd_rw;
  logic [2:0]  cmd_mode;
  logic        cmd_bcd;
  logic [15:0] cmd_count;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_count;
  logic [7:0]  rsp_status;
  logic [1:0]  a;
  logic        cs_n, rd_n, wr_n, d_oe;
  logic [7:0]  d_out, d_in;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pit_host_ctrl #(.STROBE_CYCLES(2), .RECOVERY_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sc(cmd_sc),
    .cmd_rw(cmd_rw), .cmd_mode(cmd_mode), .cmd_bcd(cmd_bcd), .cmd_count(cmd_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .rsp_count(rsp_count), .rsp_status(rsp_status),
    .a(a), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
  );

  // 8254 data model: first read returns rd_data[0], later reads rd_data[1].
  logic [7:0] rd_data [0:1];
  int         rd_idx = 0;
  assign d_in = (rd_idx == 0) ? rd_data[0] : rd_data[1];

  // Bus monitor: logs each completed strobe (address, data, direction, low length).
  logic [1:0] log_a [$];
  logic [7:0] log_d [$];
  logic       log_w [$];
  int         log_len [$];
  int         wlen = 0, rlen = 0, cs_cnt = 0, oe_bad = 0;

  always @(negedge clk) begin
    if (!cs_n) cs_cnt <= cs_cnt + 1;
    if (!wr_n) begin
      wlen <= wlen + 1;
      if (!d_oe) oe_bad <= oe_bad + 1;
    end else if (wlen > 0) begin
      log_a.push_back(a); log_d.push_back(d_out); log_w.push_back(1'b1); log_len.push_back(wlen);
      wlen <= 0;
    end
    if (!rd_n) begin
      rlen <= rlen + 1;
      if (d_oe) oe_bad <= oe_bad + 1;
    end else if (rlen > 0) begin
      log_a.push_back(a); log_d.push_back(d_in); log_w.push_back(1'b0); log_len.push_back(rlen);
      rlen   <= 0;
      rd_idx <= rd_idx + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    @(posedge clk);
    #1;
    log_a.delete(); log_d.delete(); log_w.delete(); log_len.delete();
    cs_cnt = 0;
    rd_idx = 0;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] sc, input logic [1:0] rw,
                      input logic [2:0] mode, input logic bcd, input logic [15:0] count);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_op = op; cmd_sc = sc; cmd_rw = rw; cmd_mode = mode; cmd_bcd = bcd; cmd_count = count;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("ready_back", cmd_ready, 1);
  endtask

  typedef struct {
    logic [1:0]  op, sc, rw;
    logic [2:0]  mode;
    logic        bcd;
    logic [15:0] count;
    logic [7:0]  rd0, rd1;
    logic        err;
    logic [15:0] ecount;
    logic [7:0]  estat;
    int          nbus;
    logic [1:0]  a0;
    logic [7:0]  d0;
    logic [1:0]  al;
    logic [7:0]  dl;
    logic        wl;
  } vec_t;

  vec_t vec [0:9];

  initial begin
    int cyc, n, last;
    logic [1:0] exp_a [0:2];
    logic [7:0] exp_d [0:2];

    vec[0] = '{2'b00, 2'd1, 2'b01, 3'd0, 1'b0, 16'h00A5, 8'h00, 8'h00, 1'b0, 16'h0000, 8'h00, 2, 2'd3, 8'h50, 2'd1, 8'hA5, 1'b1};
    vec[1] = '{2'b01, 2'd1, 2'b00, 3'd0, 1'b0, 16'h0000, 8'h5A, 8'h00, 1'b0, 16'h005A, 8'h00, 2, 2'd3, 8'h40, 2'd1, 8'h5A, 1'b0};
    vec[2] = '{2'b10, 2'd2, 2'b00, 3'd0, 1'b0, 16'h0000, 8'h96, 8'h00, 1'b0, 16'h0000, 8'h96, 2, 2'd3, 8'hE8, 2'd2, 8'h96, 1'b0};
    vec[3] = '{2'b00, 2'd0, 2'b00, 3'd1, 1'b0, 16'h1111, 8'h00, 8'h00, 1'b1, 16'h0000, 8'h00, 0, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0};
    vec[4] = '{2'b01, 2'd3, 2'b00, 3'd0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b1, 16'h0000, 8'h00, 0, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0};
    vec[5] = '{2'b10, 2'd3, 2'b00, 3'd0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b1, 16'h0000, 8'h00, 0, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0};
    vec[6] = '{2'b11, 2'd0, 2'b11, 3'd0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b1, 16'h0000, 8'h00, 0, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0};
    vec[7] = '{2'b00, 2'd0, 2'b10, 3'd2, 1'b1, 16'hBEEF, 8'h00, 8'h00, 1'b0, 16'h0000, 8'h00, 2, 2'd3, 8'h25, 2'd0, 8'hBE, 1'b1};
    vec[8] = '{2'b01, 2'd0, 2'b00, 3'd0, 1'b0, 16'h0000, 8'h77, 8'h00, 1'b0, 16'h7700, 8'h00, 2, 2'd3, 8'h00, 2'd0, 8'h77, 1'b0};
    vec[9] = '{2'b01, 2'd2, 2'b00, 3'd0, 1'b0, 16'h0000, 8'h11, 8'h22, 1'b0, 16'h2211, 8'h00, 3, 2'd3, 8'h80, 2'd2, 8'h22, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 2'b00; cmd_sc = 2'b00; cmd_rw = 2'b00; cmd_mode = 3'b000; cmd_bcd = 1'b0; cmd_count = 16'h0000;
    rd_data[0] = 8'h00; rd_data[1] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_rd_n", rd_n, 1);
    check("rst_wr_n", wr_n, 1);
    check("rst_d_oe", d_oe, 0);
    check("rst_a", a, 0);
    check("rst_d_out", d_out, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_err, rsp_count, rsp_status}, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;

    // PROGRAM sc=0 mode=3 rw=11: CW then LSB then MSB, each strobe two cycles.
    clear_log();
    send(2'b00, 2'd0, 2'b11, 3'd3, 1'b0, 16'h1234);
    wait_rsp(cyc);
    check("t1_err", rsp_err, 0);
    check("t1_count", rsp_count, 0);
    check("t1_nbus", log_a.size(), 3);
    exp_a[0] = 2'd3; exp_d[0] = 8'h36;
    exp_a[1] = 2'd0; exp_d[1] = 8'h34;
    exp_a[2] = 2'd0; exp_d[2] = 8'h12;
    for (int i = 0; i < 3; i++) begin
      if (log_a.size() > i) begin
        check($sformatf("t1_a%0d", i), log_a[i], exp_a[i]);
        check($sformatf("t1_d%0d", i), log_d[i], exp_d[i]);
        check($sformatf("t1_w%0d", i), log_w[i], 1);
        check($sformatf("t1_len%0d", i), log_len[i], 2);
      end
    end
    ack();

    for (int i = 0; i < 10; i++) begin
      clear_log();
      rd_data[0] = vec[i].rd0;
      rd_data[1] = vec[i].rd1;
      send(vec[i].op, vec[i].sc, vec[i].rw, vec[i].mode, vec[i].bcd, vec[i].count);
      wait_rsp(cyc);
      check($sformatf("v%0d_err", i), rsp_err, vec[i].err);
      check($sformatf("v%0d_count", i), rsp_count, vec[i].ecount);
      check($sformatf("v%0d_status", i), rsp_status, vec[i].estat);
      check($sformatf("v%0d_nbus", i), log_a.size(), vec[i].nbus);
      if (vec[i].err) begin
        check($sformatf("v%0d_latency", i), cyc, 1);
        check($sformatf("v%0d_cs_idle", i), cs_cnt, 0);
      end else if (log_a.size() > 0) begin
        last = log_a.size() - 1;
        check($sformatf("v%0d_a0", i), log_a[0], vec[i].a0);
        check($sformatf("v%0d_d0", i), log_d[0], vec[i].d0);
        check($sformatf("v%0d_w0", i), log_w[0], 1);
        check($sformatf("v%0d_alast", i), log_a[last], vec[i].al);
        check($sformatf("v%0d_dlast", i), log_d[last], vec[i].dl);
        check($sformatf("v%0d_wlast", i), log_w[last], vec[i].wl);
        check($sformatf("v%0d_len", i), log_len[last], 2);
      end
      ack();
    end

    // Response held 5 cycles: outputs stable, new command ignored, no bus traffic.
    clear_log();
    rd_data[0] = 8'h5A;
    send(2'b01, 2'd1, 2'b00, 3'd0, 1'b0, 16'h0000);
    wait_rsp(cyc);
    n = cs_cnt;
    cmd_op = 2'b00; cmd_sc = 2'd0; cmd_rw = 2'b11; cmd_count = 16'hFFFF;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t5_valid%0d", k), rsp_valid, 1);
      check($sformatf("t5_count%0d", k), rsp_count, 16'h005A);
      check($sformatf("t5_err%0d", k), rsp_err, 0);
      check($sformatf("t5_ready%0d", k), cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    check("t5_no_bus", cs_cnt, n);
    ack();
    repeat (3) @(negedge clk);
    check("t5_not_accepted", cmd_ready, 1);
    check("t5_no_bus_after", cs_cnt, n);
    check("t5_oe_ok", oe_bad, 0);

    // Reset during the strobe of the second PROGRAM write.
    clear_log();
    send(2'b00, 2'd1, 2'b01, 3'd0, 1'b0, 16'h00C3);
    n = 0;
    while (!(log_a.size() == 1 && wr_n == 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_strobe", wr_n, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_wr_n", wr_n, 1);
    check("t6_cs_n", cs_n, 1);
    check("t6_d_oe", d_oe, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t6_no_rsp%0d", k), rsp_valid, 0);
    end
    check("t6_ready", cmd_ready, 1);
    clear_log();
    rd_data[0] = 8'h34;
    rd_data[1] = 8'h12;
    send(2'b01, 2'd1, 2'b00, 3'd0, 1'b0, 16'h0000);
    wait_rsp(cyc);
    check("t6_count", rsp_count, 16'h1234);
    check("t6_nbus", log_a.size(), 3);
    if (log_a.size() == 3) begin
      check("t6_cw", log_d[0], 8'h40);
      check("t6_rd1_a", log_a[1], 1);
      check("t6_rd1_w", log_w[1], 0);
      check("t6_rd2_a", log_a[2], 1);
      check("t6_rd2_w", log_w[2], 0);
    end
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
